wash_sensor_timer: RTL and testbench
====================================

# wash_sensor_timer

Timing and sensor-emulation stage that sits directly upstream of the automatic washing-machine controller FSM and closes its loop. It consumes the controller's actuator outputs (`motor_on`, `fill_value_on`, `drain_value_on`, plus a spin request) and produces the status inputs the controller waits on: `filled`, `drained`, `cycle_timeout` and `spin_timeout`. Time is measured in prescaled ticks. The block also maintains a saturating water-level model and a sticky valve-conflict flag.

## Interface
- `PRESCALE`, default 4: clocks per tick (≥2).
- `LEVEL_MAX`, default 8: ticks of filling from empty to full.
- `CYCLE_TICKS`, default 8: ticks of `motor_on` before `cycle_timeout`.
- `SPIN_TICKS`, default 4: ticks of `spin_on` before `spin_timeout`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `motor_on` in 1: wash motor running (from controller).
- `fill_value_on` in 1: fill valve open (from controller).
- `drain_value_on` in 1: drain valve open (from controller).
- `spin_on` in 1: spin phase active.
- `filled` out 1: level == `LEVEL_MAX`.
- `drained` out 1: level == 0.
- `cycle_timeout` out 1: wash-cycle time elapsed.
- `spin_timeout` out 1: spin time elapsed.
- `level` out clog2(LEVEL_MAX+1): current water level.
- `tick` out 1: one-clock prescaler pulse.
- `valve_conflict` out 1: sticky flag, set when fill and drain are both open.

## Operation
- Reset (async, while `reset`=1) clears all registers: `pre_cnt`=0, `level`=0, `cyc_cnt`=0, `spin_cnt`=0, `valve_conflict`=0. Outputs under reset: `tick`=0, `filled`=0, `drained`=1, `cycle_timeout`=0, `spin_timeout`=0, `level`=0.
- Prescaler: `pre_cnt` counts 0..PRESCALE-1 and wraps. It runs free regardless of the other inputs. `tick` = (`pre_cnt`==PRESCALE-1).
- Level model, updated only on clocks where `tick`=1:
  - fill=1, drain=0, level<LEVEL_MAX: level+1.
  - drain=1, fill=0, level>0: level-1.
  - All other cases hold the level. It saturates at 0 and at LEVEL_MAX and never wraps.
- `filled` and `drained` are decoded from the registered `level`. They are never both 1, because LEVEL_MAX≥1.
- Cycle timer:
  - Any clock with `motor_on`=0 clears `cyc_cnt` to 0 synchronously.
  - With `motor_on`=1 and `tick`=1, `cyc_cnt` increments and saturates at CYCLE_TICKS.
  - `cycle_timeout` = `motor_on` && `cyc_cnt`==CYCLE_TICKS. It is a level and holds until `motor_on` drops.
- Spin timer: same structure as the cycle timer, driven by `spin_on`, `spin_cnt` and SPIN_TICKS, producing `spin_timeout`.
- Valve conflict:
  - `valve_conflict` sets on any clock edge where `fill_value_on` && `drain_value_on`, and clears only on reset.
  - The level holds while the conflict persists.
- Motor and spin dropping mid-count: the count is lost. Re-asserting restarts from 0.
- `motor_on` and `spin_on` both high: the two timers run independently. No priority is applied.

## Timing
- All state is registered; status outputs are combinational decodes of the registers and the enable inputs.
- After reset release, the first `tick` is in the PRESCALE-th clock cycle: `pre_cnt` reaches PRESCALE-1 after PRESCALE-1 edges.
- Level latency: starting from empty with fill held, `filled` rises after LEVEL_MAX ticks, i.e. LEVEL_MAX·PRESCALE clocks, ±(PRESCALE-1) depending on prescaler phase.
- Timeout latency: `cycle_timeout` rises CYCLE_TICKS ticks after `motor_on` rises. It falls combinationally in the same cycle `motor_on` falls, and the counter is 0 on the next edge.
- An input change applies at the next rising edge. There is no input synchronisation; the controller is on the same `clk`.

## Test plan
- Reset check: assert `reset` mid-count, with level=5 and `cyc_cnt`=3 → all outputs immediately return to their reset values (`drained`=1, `level`=0, timeouts 0, `valve_conflict`=0).
- Fill saturation (defaults): hold `fill_value_on` for 40 clocks from reset → `level` steps 1..8, one step per 4 clocks. `filled`=1 at 32 clocks. `level` stays at 8 afterwards, with no wrap.
- Drain: from level 8, hold `drain_value_on` → `drained`=1 after 32 clocks. `level` stays at 0.
- Cycle timer: `motor_on`=1 → `cycle_timeout`=1 after 8 ticks and holds. Drop `motor_on` after 5 ticks, then reassert → the timeout needs a full 8 fresh ticks.
- Spin timer: `spin_on`=1 for 4 ticks → `spin_timeout`=1. It deasserts in the same cycle `spin_on` drops.
- Conflict: at level 4, assert fill and drain together for 10 clocks → `level` stays 4 and `valve_conflict`=1. The flag stays 1 after both valves close, until reset.

Source files
------------

// File: rtl/wash_sensor_timer_if.sv
// Actuator/status bundle between the washing-machine controller (master)
// and the sensor/timer emulation stage (slave).
interface wash_sensor_timer_if #(
  parameter int LEVEL_MAX = 8
);
  localparam int LW = $clog2(LEVEL_MAX + 1);

  logic          motor_on;
  logic          fill_value_on;
  logic          drain_value_on;
  logic          spin_on;
  logic          filled;
  logic          drained;
  logic          cycle_timeout;
  logic          spin_timeout;
  logic [LW-1:0] level;
  logic          tick;
  logic          valve_conflict;

  modport master (
    output motor_on, fill_value_on, drain_value_on, spin_on,
    input  filled, drained, cycle_timeout, spin_timeout, level, tick, valve_conflict
  );

  modport slave (
    input  motor_on, fill_value_on, drain_value_on, spin_on,
    output filled, drained, cycle_timeout, spin_timeout, level, tick, valve_conflict
  );
endinterface

// File: rtl/wash_sensor_timer.sv
// Sensor emulation for the wash controller: prescaled tick, saturating water
// level, motor/spin phase timers and a sticky fill/drain conflict flag.
module wash_sensor_timer_cnt #(
  parameter int TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tick,
  output logic timeout
);
  localparam int CW = $clog2(TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Dropping the enable discards the partial count.
  always_comb begin
    cnt_d = cnt_q;
    if (!en)                             cnt_d = '0;
    else if (tick && cnt_q != CW'(TICKS)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = en && (cnt_q == CW'(TICKS));
endmodule

module wash_sensor_timer #(
  parameter int PRESCALE    = 4,
  parameter int LEVEL_MAX   = 8,
  parameter int CYCLE_TICKS = 8,
  parameter int SPIN_TICKS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  wash_sensor_timer_if.slave   bus
);
  localparam int PW = $clog2(PRESCALE);
  localparam int LW = $clog2(LEVEL_MAX + 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [LW-1:0] level_q, level_d;
  logic          conflict_q, conflict_d;
  logic          tick;

  assign tick = (pre_cnt_q == PW'(PRESCALE - 1));

  always_comb begin
    pre_cnt_d  = tick ? '0 : pre_cnt_q + 1'b1;
    conflict_d = conflict_q | (bus.fill_value_on & bus.drain_value_on);
    level_d    = level_q;
    // Both valves open (or neither) holds the level.
    if (tick) begin
      if (bus.fill_value_on && !bus.drain_value_on && level_q != LW'(LEVEL_MAX))
        level_d = level_q + 1'b1;
      else if (bus.drain_value_on && !bus.fill_value_on && level_q != '0)
        level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q  <= '0;
      level_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      level_q    <= level_d;
      conflict_q <= conflict_d;
    end
  end

  wash_sensor_timer_cnt #(.TICKS(CYCLE_TICKS)) u_cyc (
    .clk(clk), .rst(reset), .en(bus.motor_on), .tick(tick), .timeout(bus.cycle_timeout)
  );

  wash_sensor_timer_cnt #(.TICKS(SPIN_TICKS)) u_spin (
    .clk(clk), .rst(reset), .en(bus.spin_on), .tick(tick), .timeout(bus.spin_timeout)
  );

  assign bus.tick           = tick;
  assign bus.level          = level_q;
  assign bus.filled         = (level_q == LW'(LEVEL_MAX));
  assign bus.drained        = (level_q == '0);
  assign bus.valve_conflict = conflict_q;
endmodule

// File: tb/tb_wash_sensor_timer.sv
// Random + directed check of wash_sensor_timer against a tick-count model.
module tb_wash_sensor_timer;
  localparam int P  = 4;
  localparam int LM = 8;
  localparam int CT = 8;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  wash_sensor_timer_if #(.LEVEL_MAX(LM)) bus ();

  wash_sensor_timer #(.PRESCALE(P), .LEVEL_MAX(LM), .CYCLE_TICKS(CT), .SPIN_TICKS(ST)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: edges since reset, level as a clamped integer, ticks seen while enabled.
  int m_edges, m_lvl, m_cyc_ticks, m_spin_ticks;
  bit m_conf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges = 0; m_lvl = 0; m_cyc_ticks = 0; m_spin_ticks = 0; m_conf = 0;
    end else begin
      bit t;
      t = (m_edges % P) == P - 1;
      if (bus.fill_value_on && bus.drain_value_on) m_conf = 1;
      if (t && bus.fill_value_on && !bus.drain_value_on) m_lvl = (m_lvl + 1 > LM) ? LM : m_lvl + 1;
      if (t && bus.drain_value_on && !bus.fill_value_on) m_lvl = (m_lvl - 1 < 0) ? 0 : m_lvl - 1;
      m_cyc_ticks  = bus.motor_on ? m_cyc_ticks + int'(t) : 0;
      m_spin_ticks = bus.spin_on  ? m_spin_ticks + int'(t) : 0;
      m_edges++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_tick",    32'(bus.tick),           32'(((m_edges % P) == P - 1) && !reset));
    chk("m_level",   32'(bus.level),          32'(m_lvl));
    chk("m_filled",  32'(bus.filled),         32'(m_lvl == LM));
    chk("m_drained", 32'(bus.drained),        32'(m_lvl == 0));
    chk("m_cyc_to",  32'(bus.cycle_timeout),  32'(bus.motor_on && m_cyc_ticks >= CT));
    chk("m_spin_to", 32'(bus.spin_timeout),   32'(bus.spin_on && m_spin_ticks >= ST));
    chk("m_conf",    32'(bus.valve_conflict), 32'(m_conf));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.motor_on = 0; bus.fill_value_on = 0; bus.drain_value_on = 0; bus.spin_on = 0;
    step(2);
    chk("rst_drained", 32'(bus.drained), 1);
    chk("rst_level",   32'(bus.level), 0);
    chk("rst_tick",    32'(bus.tick), 0);

    // Fill from empty: first tick after 3 edges, level moves on every 4th edge.
    reset = 1'b0; bus.fill_value_on = 1;
    step(3);  chk("first_tick", 32'(bus.tick), 1);
    step(28); chk("fill31_level", 32'(bus.level), 7); chk("fill31_filled", 32'(bus.filled), 0);
    step(1);  chk("fill32_level", 32'(bus.level), 8); chk("fill32_filled", 32'(bus.filled), 1);
    step(8);  chk("fill40_sat", 32'(bus.level), 8);

    bus.fill_value_on = 0; bus.drain_value_on = 1;
    step(31); chk("drain31_drained", 32'(bus.drained), 0); chk("drain31_level", 32'(bus.level), 1);
    step(1);  chk("drain32_drained", 32'(bus.drained), 1);
    step(4);  chk("drain_sat", 32'(bus.level), 0);
    bus.drain_value_on = 0;

    bus.motor_on = 1;
    step(31); chk("cyc31", 32'(bus.cycle_timeout), 0);
    step(1);  chk("cyc32", 32'(bus.cycle_timeout), 1);
    step(8);  chk("cyc_hold", 32'(bus.cycle_timeout), 1);
    bus.motor_on = 0; #1 chk("cyc_drop_comb", 32'(bus.cycle_timeout), 0);
    step(4);
    bus.motor_on = 1; step(20); bus.motor_on = 0; step(4);
    bus.motor_on = 1;
    step(31); chk("cyc_restart31", 32'(bus.cycle_timeout), 0);
    step(1);  chk("cyc_restart32", 32'(bus.cycle_timeout), 1);
    bus.motor_on = 0;

    bus.spin_on = 1;
    step(15); chk("spin15", 32'(bus.spin_timeout), 0);
    step(1);  chk("spin16", 32'(bus.spin_timeout), 1);
    bus.spin_on = 0; #1 chk("spin_drop_comb", 32'(bus.spin_timeout), 0);
    step(4);

    bus.fill_value_on = 1;
    step(16); chk("conf_pre_level", 32'(bus.level), 4);
    bus.drain_value_on = 1;
    step(10); chk("conf_level", 32'(bus.level), 4); chk("conf_flag", 32'(bus.valve_conflict), 1);
    bus.fill_value_on = 0; bus.drain_value_on = 0;
    step(6);  chk("conf_sticky", 32'(bus.valve_conflict), 1);

    // Async reset mid-count: level 5, cycle counter at 3.
    bus.fill_value_on = 1; step(4); bus.fill_value_on = 0;
    chk("pre_rst_level", 32'(bus.level), 5);
    bus.motor_on = 1; step(12);
    reset = 1'b1; #1;
    chk("arst_level",   32'(bus.level), 0);
    chk("arst_drained", 32'(bus.drained), 1);
    chk("arst_conf",    32'(bus.valve_conflict), 0);
    chk("arst_cyc_to",  32'(bus.cycle_timeout), 0);
    chk("arst_tick",    32'(bus.tick), 0);
    bus.motor_on = 0;
    step(2); reset = 1'b0;

    // Random phase, checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.motor_on = ~bus.motor_on;
      if ($urandom_range(0, 9)  == 0) bus.spin_on = ~bus.spin_on;
      if ($urandom_range(0, 11) == 0) bus.fill_value_on = ~bus.fill_value_on;
      if ($urandom_range(0, 11) == 0) bus.drain_value_on = ~bus.drain_value_on;
      if (bus.fill_value_on && bus.drain_value_on && $urandom_range(0, 3) != 0) bus.drain_value_on = 0;
      reset = ($urandom_range(0, 599) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
